// File: rtl/stage_memory.sv
// Memory-access pipeline stage: issues data-memory requests, stalls while memory is busy,
// aligns load data and registers writeback values. Optional: MEM_MISALIGN_CHECK_EN.
module stage_memory (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  execute_rd,
  input  logic        execute_regfile_wr_enable,
  input  logic [1:0]  execute_result_src,
  input  logic        execute_datamem_wr_enable,
  input  logic [2:0]  execute_funct3,
  input  logic [31:0] execute_alu_result,
  input  logic [31:0] execute_wr_datamem_data,
  input  logic [31:0] execute_instr_addr_plus,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  mem_rd,
  output logic        mem_regfile_wr_enable,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_instr_addr_plus,
  output logic        mem_misaligned
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic        is_load, is_store, misaligned, access;
  logic [1:0]  idx;
  logic [3:0]  store_be;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  logic [4:0]  mem_rd_q;
  logic        mem_wr_en_q, mem_misaligned_q;
  logic [1:0]  mem_src_q;
  logic [31:0] mem_alu_q, mem_read_q, mem_plus_q;

  assign is_load  = (execute_result_src == 2'b01);
  assign is_store = execute_datamem_wr_enable;
  assign idx      = execute_alu_result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (is_load || is_store) &&
                      (((execute_funct3[1:0] == 2'b01) && execute_alu_result[0]) ||
                       ((execute_funct3 == 3'b010) && (idx != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Inputs stay frozen by mem_stall while waiting, so the request is driven purely from them.
  assign access    = (is_load || is_store) && !misaligned;
  assign dmem_req  = rst_n && access;
  assign mem_stall = rst_n && access && !dmem_ready;
  assign dmem_we   = dmem_req && is_store;
  assign dmem_addr = {execute_alu_result[31:2], 2'b00};
  assign dmem_be   = !dmem_req ? 4'b0000 : (is_store ? store_be : 4'b1111);

  always_comb begin
    dmem_wdata = execute_wr_datamem_data;
    store_be   = 4'b0000;
    case (execute_funct3)
      3'b000: begin
        dmem_wdata = {4{execute_wr_datamem_data[7:0]}};
        store_be   = 4'b0001 << idx;
      end
      3'b001: begin
        dmem_wdata = {2{execute_wr_datamem_data[15:0]}};
        store_be   = 4'b0011 << {idx[1], 1'b0};
      end
      3'b010:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign load_byte = dmem_rdata[{idx, 3'b000} +: 8];
  assign load_half = idx[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (execute_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = dmem_rdata;
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (access && !dmem_ready) state_q <= S_WAIT;
        S_WAIT:  if (dmem_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rd_q         <= 5'd0;
      mem_wr_en_q      <= 1'b0;
      mem_src_q        <= 2'b00;
      mem_alu_q        <= 32'd0;
      mem_read_q       <= 32'd0;
      mem_plus_q       <= 32'd0;
      mem_misaligned_q <= 1'b0;
    end else if (mem_stall) begin
      // Bubble so a still-pending instruction is neither written back nor forwarded.
      mem_rd_q         <= 5'd0;
      mem_wr_en_q      <= 1'b0;
      mem_src_q        <= 2'b00;
      mem_alu_q        <= execute_alu_result;
      mem_read_q       <= 32'd0;
      mem_plus_q       <= execute_instr_addr_plus;
      mem_misaligned_q <= 1'b0;
    end else begin
      mem_rd_q         <= execute_rd;
      mem_wr_en_q      <= execute_regfile_wr_enable && !misaligned;
      mem_src_q        <= execute_result_src;
      mem_alu_q        <= execute_alu_result;
      mem_read_q       <= (is_load && !misaligned) ? load_data : 32'd0;
      mem_plus_q       <= execute_instr_addr_plus;
      mem_misaligned_q <= misaligned;
    end
  end

  assign mem_rd                = mem_rd_q;
  assign mem_regfile_wr_enable = mem_wr_en_q;
  assign mem_result_src        = mem_src_q;
  assign mem_alu_result        = mem_alu_q;
  assign mem_read_data         = mem_read_q;
  assign mem_instr_addr_plus   = mem_plus_q;
  assign mem_misaligned        = mem_misaligned_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: zero-wait vector table plus multi-cycle stall,
// reset-in-wait and misalignment sequences.
module tb_stage_memory;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  execute_rd;
  logic        execute_regfile_wr_enable;
  logic [1:0]  execute_result_src;
  logic        execute_datamem_wr_enable;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_alu_result;
  logic [31:0] execute_wr_datamem_data;
  logic [31:0] execute_instr_addr_plus;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [4:0]  mem_rd;
  logic        mem_regfile_wr_enable;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_read_data, mem_instr_addr_plus;
  logic        mem_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_memory dut (
    .clk(clk), .rst_n(rst_n),
    .execute_rd(execute_rd),
    .execute_regfile_wr_enable(execute_regfile_wr_enable),
    .execute_result_src(execute_result_src),
    .execute_datamem_wr_enable(execute_datamem_wr_enable),
    .execute_funct3(execute_funct3),
    .execute_alu_result(execute_alu_result),
    .execute_wr_datamem_data(execute_wr_datamem_data),
    .execute_instr_addr_plus(execute_instr_addr_plus),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_rd(mem_rd),
    .mem_regfile_wr_enable(mem_regfile_wr_enable),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_instr_addr_plus(mem_instr_addr_plus),
    .mem_misaligned(mem_misaligned)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wr_en;
    logic [1:0]  src;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic wr_en, input logic [1:0] src,
                       input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic ready);
    execute_rd                = rd;
    execute_regfile_wr_enable = wr_en;
    execute_result_src        = src;
    execute_datamem_wr_enable = we;
    execute_funct3            = f3;
    execute_alu_result        = addr;
    execute_wr_datamem_data   = wdata;
    execute_instr_addr_plus   = addr + 32'd4;
    dmem_rdata                = rdata;
    dmem_ready                = ready;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_wr_en"}, 32'(mem_regfile_wr_enable), 32'd0);
    chk({tag, "_mem_src"}, 32'(mem_result_src), 32'd0);
    chk({tag, "_mem_alu"}, mem_alu_result, 32'd0);
    chk({tag, "_mem_read"}, mem_read_data, 32'd0);
    chk({tag, "_mem_plus"}, mem_instr_addr_plus, 32'd0);
    chk({tag, "_mem_misal"}, 32'(mem_misaligned), 32'd0);
  endtask

  initial begin
    int stall_cycles;
    vecs.push_back('{5'd1,  1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, "SW_100"});
    vecs.push_back('{5'd2,  1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 1'b1, 1'b1, 1'b1, 4'h8, 32'hABABABAB, 32'h0, "SB_103"});
    vecs.push_back('{5'd3,  1'b0, 2'b00, 1'b1, 3'b000, 32'h101, 32'h00000055, 32'h0, 1'b1, 1'b1, 1'b1, 4'h2, 32'h55555555, 32'h0, "SB_101"});
    vecs.push_back('{5'd4,  1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234CAFE, 32'h0, 1'b1, 1'b1, 1'b1, 4'hC, 32'hCAFECAFE, 32'h0, "SH_102"});
    vecs.push_back('{5'd5,  1'b1, 2'b01, 1'b0, 3'b000, 32'h101, 32'h0, 32'h123480FF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80, "LB_101"});
    vecs.push_back('{5'd6,  1'b1, 2'b01, 1'b0, 3'b100, 32'h101, 32'h0, 32'h123480FF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h00000080, "LBU_101"});
    vecs.push_back('{5'd7,  1'b1, 2'b01, 1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000BEEF, "LHU_102"});
    vecs.push_back('{5'd8,  1'b1, 2'b01, 1'b0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFFBEEF, "LH_102"});
    vecs.push_back('{5'd9,  1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 32'h13572468, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h13572468, "LW_100"});
    vecs.push_back('{5'd10, 1'b1, 2'b01, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00810000, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF81, "LB_102"});
    vecs.push_back('{5'd11, 1'b1, 2'b01, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00007FFF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h00007FFF, "LH_100"});
    vecs.push_back('{5'd12, 1'b1, 2'b01, 1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, "LD_bad_f3"});
    vecs.push_back('{5'd13, 1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "ALU_ready_ignored"});
    vecs.push_back('{5'd14, 1'b1, 2'b10, 1'b0, 3'b010, 32'h2000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "PC4_no_access"});

    // Reset with a pending store on the inputs
    rst_n = 1'b0;
    drive(5'd31, 1'b1, 2'b01, 1'b1, 3'b010, 32'h100, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk_zero_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait vectors, driven back to back
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr_en, vecs[i].src, vecs[i].we, vecs[i].f3,
            vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ready);
      #1;
      chk({vecs[i].name, "_req"}, 32'(dmem_req), 32'(vecs[i].exp_req));
      chk({vecs[i].name, "_we"}, 32'(dmem_we), 32'(vecs[i].exp_we));
      chk({vecs[i].name, "_be"}, 32'(dmem_be), 32'(vecs[i].exp_be));
      chk({vecs[i].name, "_stall"}, 32'(mem_stall), 32'd0);
      if (vecs[i].exp_req) chk({vecs[i].name, "_addr"}, dmem_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].exp_we) chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_mem_rd"}, 32'(mem_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_mem_wr_en"}, 32'(mem_regfile_wr_enable), 32'(vecs[i].wr_en));
      chk({vecs[i].name, "_mem_src"}, 32'(mem_result_src), 32'(vecs[i].src));
      chk({vecs[i].name, "_mem_alu"}, mem_alu_result, vecs[i].addr);
      chk({vecs[i].name, "_mem_plus"}, mem_instr_addr_plus, vecs[i].addr + 32'd4);
      chk({vecs[i].name, "_mem_read"}, mem_read_data, vecs[i].exp_rdata);
      $display("vec %0d %s req=%0b be=%h read_data=%h", i, vecs[i].name, vecs[i].exp_req, dmem_be, mem_read_data);
    end

    // LB 0x101 with memory ready after 3 cycles: bubbles while stalled
    stall_cycles = 0;
    @(negedge clk);
    drive(5'd20, 1'b1, 2'b01, 1'b0, 3'b000, 32'h101, 32'h0, 32'hXXXXXXXX, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_stall === 1'b1) stall_cycles++;
      chk("wait_req", 32'(dmem_req), 32'd1);
      chk("wait_be", 32'(dmem_be), 32'hF);
      @(posedge clk);
      #1;
      chk("wait_bubble_wr_en", 32'(mem_regfile_wr_enable), 32'd0);
      chk("wait_bubble_rd", 32'(mem_rd), 32'd0);
      chk("wait_bubble_src", 32'(mem_result_src), 32'd0);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h123480FF;
    #1;
    chk("wait_stall_count", 32'(stall_cycles), 32'd3);
    chk("wait_done_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("wait_lb_read", mem_read_data, 32'hFFFFFF80);
    chk("wait_lb_rd", 32'(mem_rd), 32'd20);
    chk("wait_lb_wr_en", 32'(mem_regfile_wr_enable), 32'd1);
    $display("seq stall_lb stall_cycles=%0d read_data=%h", stall_cycles, mem_read_data);

    // Reset asserted while waiting abandons the request
    @(negedge clk);
    drive(5'd21, 1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rw_req_before", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_req_in_rst", 32'(dmem_req), 32'd0);
    chk("rw_stall_in_rst", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk_zero_outputs("rw");
    @(negedge clk);
    drive(5'd0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rw_req_after", 32'(dmem_req), 32'd0);
    $display("seq reset_in_wait req=%0b stall=%0b", dmem_req, mem_stall);

    // LW at 0x102: trapped when the misalignment check is built in
    @(negedge clk);
`ifdef MEM_MISALIGN_CHECK_EN
    drive(5'd22, 1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A5A5A5, 1'b0);
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("mis_flag", 32'(mem_misaligned), 32'd1);
    chk("mis_wr_en", 32'(mem_regfile_wr_enable), 32'd0);
    chk("mis_read", mem_read_data, 32'd0);
`else
    drive(5'd22, 1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A5A5A5, 1'b1);
    #1;
    chk("mis_req", 32'(dmem_req), 32'd1);
    chk("mis_addr", dmem_addr, 32'h100);
    @(posedge clk);
    #1;
    chk("mis_flag", 32'(mem_misaligned), 32'd0);
    chk("mis_wr_en", 32'(mem_regfile_wr_enable), 32'd1);
    chk("mis_read", mem_read_data, 32'hA5A5A5A5);
`endif
    $display("seq lw_102 misaligned=%0b read_data=%h", mem_misaligned, mem_read_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
